// File: rtl/pe_array_feeder_if.sv
// Weight and activation valid/ready channels feeding the PE array sequencer.
// The master side is the upstream producer; the slave side is pe_array_feeder.
interface pe_array_feeder_if #(
  parameter int DATA_W = 27
);
  logic              w_valid_in;
  logic              w_ready_out;
  logic [DATA_W-1:0] w_data_in;
  logic              a_valid_in;
  logic              a_ready_out;
  logic [DATA_W-1:0] a_data_in;

  modport master (
    output w_valid_in, w_data_in, a_valid_in, a_data_in,
    input  w_ready_out, a_ready_out
  );

  modport slave (
    input  w_valid_in, w_data_in, a_valid_in, a_data_in,
    output w_ready_out, a_ready_out
  );
endinterface

// File: rtl/pe_array_feeder.sv
// Sequencer for the 3x3 weight-stationary PE array: a 12-slot frame of 9 weights
// followed by 3 activations, with a double-buffered weight bank and an activation FIFO.
module pe_array_feeder #(
  parameter int DATA_W = 27,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  pe_array_feeder_if.slave         bus,
  output logic [DATA_W-1:0]        data_out,
  output logic [3:0]               slot_out,
  output logic                     weights_valid_out,
  output logic                     underflow_out,
  output logic [CNT_W-1:0]         underflow_cnt_out,
  output logic [$clog2(DEPTH):0]   fifo_count_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [3:0]        slot;
  logic [DATA_W-1:0] active_w [9];
  logic [DATA_W-1:0] shadow_w [9];
  logic [3:0]        shadow_idx;
  logic              shadow_full;
  logic              weights_valid;
  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;
  logic [CNT_W-1:0]  uf_cnt;

  logic w_fire;
  logic push;
  logic pop_try;
  logic pop;
  logic underflow;
  logic frame_end;

  // Activation slots only consume FIFO words once a weight set is live.
  always_comb begin
    w_fire    = bus.w_valid_in && !shadow_full;
    push      = bus.a_valid_in && (count < FULL_COUNT);
    pop_try   = (slot >= 4'd9) && weights_valid;
    pop       = pop_try && (count != '0);
    underflow = pop_try && (count == '0);
    frame_end = (slot == 4'd11);
  end

  always_comb begin
    data_out = '0;
    if (slot < 4'd9) begin
      data_out = active_w[slot];
    end else if (pop) begin
      data_out = fifo_mem[rd_ptr];
    end
  end

  assign bus.w_ready_out   = !shadow_full;
  assign bus.a_ready_out   = (count < FULL_COUNT);
  assign slot_out          = slot;
  assign weights_valid_out = weights_valid;
  assign underflow_out     = underflow;
  assign underflow_cnt_out = uf_cnt;
  assign fifo_count_out    = count;

  // Control state; the bank swap only happens on the 11->0 frame boundary
  // so a frame in progress always sees a single consistent weight set.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      slot          <= '0;
      shadow_idx    <= '0;
      shadow_full   <= 1'b0;
      weights_valid <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      uf_cnt        <= '0;
      for (int i = 0; i < 9; i++) begin
        active_w[i] <= '0;
        shadow_w[i] <= '0;
      end
    end else begin
      slot <= frame_end ? 4'd0 : slot + 4'd1;

      if (w_fire) begin
        shadow_w[shadow_idx] <= bus.w_data_in;
        if (shadow_idx == 4'd8) begin
          shadow_idx  <= '0;
          shadow_full <= 1'b1;
        end else begin
          shadow_idx <= shadow_idx + 4'd1;
        end
      end

      if (frame_end && shadow_full) begin
        active_w      <= shadow_w;
        shadow_full   <= 1'b0;
        weights_valid <= 1'b1;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (underflow && (uf_cnt != '1)) uf_cnt <= uf_cnt + 1'b1;
    end
  end

  // FIFO storage carries no reset; the pointers alone define its contents.
  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= bus.a_data_in;
  end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Directed bench for pe_array_feeder; a second instance with CNT_W=2 shares
// the stimulus so the underflow counter saturation can be observed.
module tb_pe_array_feeder;
  localparam int DATA_W = 27;
  localparam int DEPTH  = 8;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  pe_array_feeder_if #(.DATA_W(DATA_W)) mainBus ();
  pe_array_feeder_if #(.DATA_W(DATA_W)) satBus ();

  logic [DATA_W-1:0]      dataOut,  satDataOut;
  logic [3:0]             slotOut,  satSlotOut;
  logic                   wvOut,    satWvOut;
  logic                   ufOut,    satUfOut;
  logic [15:0]            ufCnt;
  logic [1:0]             satUfCnt;
  logic [$clog2(DEPTH):0] fifoCnt,  satFifoCnt;

  assign satBus.w_valid_in = mainBus.w_valid_in;
  assign satBus.w_data_in  = mainBus.w_data_in;
  assign satBus.a_valid_in = mainBus.a_valid_in;
  assign satBus.a_data_in  = mainBus.a_data_in;

  pe_array_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .bus(mainBus),
    .data_out(dataOut), .slot_out(slotOut), .weights_valid_out(wvOut),
    .underflow_out(ufOut), .underflow_cnt_out(ufCnt), .fifo_count_out(fifoCnt)
  );

  pe_array_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(2)) dutSat (
    .clk_in(clk_in), .rst_in(rst_in), .bus(satBus),
    .data_out(satDataOut), .slot_out(satSlotOut), .weights_valid_out(satWvOut),
    .underflow_out(satUfOut), .underflow_cnt_out(satUfCnt), .fifo_count_out(satFifoCnt)
  );

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
  endtask

  // Inputs change at the falling edge; outputs are sampled there as well.
  task automatic applyStimulus(input logic wv, input logic [DATA_W-1:0] wd,
                               input logic av, input logic [DATA_W-1:0] ad);
    mainBus.w_valid_in = wv;
    mainBus.w_data_in  = wd;
    mainBus.a_valid_in = av;
    mainBus.a_data_in  = ad;
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0, 1'b0, '0);
  endtask

  task automatic resetDut();
    rst_in = 1'b1;
    idle(3);
    rst_in = 1'b0;
  endtask

  task automatic loadWeights(input logic [DATA_W-1:0] base);
    for (int k = 0; k < 9; k++) applyStimulus(1'b1, base + DATA_W'(k), 1'b0, '0);
  endtask

  initial begin
    rst_in = 1'b1;
    mainBus.w_valid_in = 1'b0;
    mainBus.w_data_in  = '0;
    mainBus.a_valid_in = 1'b0;
    mainBus.a_data_in  = '0;
    @(negedge clk_in);

    // Reset values, then two idle frames
    resetDut();
    checkOutput("rst w_ready", 32'(mainBus.w_ready_out), 32'd1);
    checkOutput("rst a_ready", 32'(mainBus.a_ready_out), 32'd1);
    checkOutput("rst wvalid", 32'(wvOut), 32'd0);
    checkOutput("rst underflow", 32'(ufOut), 32'd0);
    checkOutput("rst ufcnt", 32'(ufCnt), 32'd0);
    checkOutput("rst fifo", 32'(fifoCnt), 32'd0);
    for (int i = 0; i < 24; i++) begin
      checkOutput("t1 slot", 32'(slotOut), 32'(i % 12));
      checkOutput("t1 data", 32'(dataOut), 32'd0);
      idle(1);
    end
    checkOutput("t1 ufcnt", 32'(ufCnt), 32'd0);

    // Weights 1..9 then activations A,B,C
    resetDut();
    loadWeights(27'h1);
    checkOutput("t2 wready full", 32'(mainBus.w_ready_out), 32'd0);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) checkOutput("t2 wvalid pre", 32'(wvOut), 32'd0);
      applyStimulus(1'b0, '0, 1'b1, 27'hA + DATA_W'(k));
    end
    checkOutput("t2 wvalid", 32'(wvOut), 32'd1);
    checkOutput("t2 fifo", 32'(fifoCnt), 32'd3);
    checkOutput("t2 wready", 32'(mainBus.w_ready_out), 32'd1);
    for (int s = 0; s < 12; s++) begin
      checkOutput("t2 slot", 32'(slotOut), 32'(s));
      checkOutput("t2 data", 32'(dataOut), (s < 9) ? 32'(s + 1) : 32'(10 + s - 9));
      idle(1);
    end
    checkOutput("t2 fifo drained", 32'(fifoCnt), 32'd0);

    // Second set completes in slot 11: swap is deferred one frame
    resetDut();
    loadWeights(27'h1);
    idle(3);
    for (int s = 0; s < 12; s++) begin
      if (s < 9) checkOutput("t3 f2 data", 32'(dataOut), 32'(s + 1));
      if (s >= 3) applyStimulus(1'b1, 27'h11 + DATA_W'(s - 3), 1'b0, '0);
      else idle(1);
    end
    checkOutput("t3 shadow full", 32'(mainBus.w_ready_out), 32'd0);
    for (int s = 0; s < 12; s++) begin
      if (s < 9) checkOutput("t3 f3 data", 32'(dataOut), 32'(s + 1));
      idle(1);
    end
    for (int s = 0; s < 9; s++) begin
      checkOutput("t3 f4 data", 32'(dataOut), 32'h11 + 32'(s));
      idle(1);
    end

    // FIFO full with no active weights; overflow push refused
    resetDut();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 27'h20 + DATA_W'(i));
    checkOutput("t4 a_ready", 32'(mainBus.a_ready_out), 32'd0);
    checkOutput("t4 fifo full", 32'(fifoCnt), 32'd8);
    applyStimulus(1'b0, '0, 1'b1, 27'h99);
    checkOutput("t4 fifo held", 32'(fifoCnt), 32'd8);
    checkOutput("t4 slot9 data", 32'(dataOut), 32'd0);
    loadWeights(27'h1);
    idle(6);
    checkOutput("t4 wvalid", 32'(wvOut), 32'd1);
    idle(9);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t4 head", 32'(dataOut), 32'h20 + 32'(k));
      idle(1);
    end
    checkOutput("t4 fifo after pops", 32'(fifoCnt), 32'd5);

    // Underflow pulse and saturation on the CNT_W=2 instance
    resetDut();
    loadWeights(27'h1);
    applyStimulus(1'b0, '0, 1'b1, 27'h31);
    applyStimulus(1'b0, '0, 1'b1, 27'h32);
    idle(1);
    checkOutput("t5 wvalid", 32'(wvOut), 32'd1);
    checkOutput("t5 fifo", 32'(fifoCnt), 32'd2);
    idle(9);
    checkOutput("t5 slot9 data", 32'(dataOut), 32'h31);
    checkOutput("t5 slot9 uf", 32'(ufOut), 32'd0);
    idle(1);
    checkOutput("t5 slot10 data", 32'(dataOut), 32'h32);
    checkOutput("t5 slot10 uf", 32'(ufOut), 32'd0);
    idle(1);
    checkOutput("t5 slot11 data", 32'(dataOut), 32'd0);
    checkOutput("t5 slot11 uf", 32'(ufOut), 32'd1);
    checkOutput("t5 slot11 ufcnt", 32'(ufCnt), 32'd0);
    idle(1);
    checkOutput("t5 uf cleared", 32'(ufOut), 32'd0);
    checkOutput("t5 ufcnt", 32'(ufCnt), 32'd1);
    checkOutput("t5 sat ufcnt", 32'(satUfCnt), 32'd1);
    idle(24);
    checkOutput("t5 ufcnt 7", 32'(ufCnt), 32'd7);
    checkOutput("t5 sat hold", 32'(satUfCnt), 32'd3);

    // Reset mid-frame with buffered activations and a partial shadow set
    resetDut();
    loadWeights(27'h1);
    idle(3);
    for (int s = 0; s < 5; s++) applyStimulus(1'b1, 27'h40 + DATA_W'(s), 1'b0, '0);
    for (int s = 5; s < 10; s++) applyStimulus(1'b0, '0, 1'b1, 27'h50 + DATA_W'(s));
    checkOutput("t6 pre slot", 32'(slotOut), 32'd10);
    checkOutput("t6 pre fifo", 32'(fifoCnt), 32'd4);
    rst_in = 1'b1;
    idle(1);
    rst_in = 1'b0;
    checkOutput("t6 slot", 32'(slotOut), 32'd0);
    checkOutput("t6 fifo", 32'(fifoCnt), 32'd0);
    checkOutput("t6 w_ready", 32'(mainBus.w_ready_out), 32'd1);
    checkOutput("t6 wvalid", 32'(wvOut), 32'd0);
    checkOutput("t6 data", 32'(dataOut), 32'd0);
    loadWeights(27'h61);
    idle(3);
    for (int s = 0; s < 9; s++) begin
      checkOutput("t6 fresh set", 32'(dataOut), 32'h61 + 32'(s));
      idle(1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
